// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    localparam int unsigned DEF_NUM_REQ    = 4;
    localparam int unsigned DEF_FIFO_WIDTH = 8;
    localparam int unsigned DEF_MAX_BURST  = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first set bit of req at or after start, wrapping.
module rr_pick #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [IW-1:0] winner,
    output logic          found
);

    int idx;

    // Walk from the farthest offset back to start so the nearest requester is written last.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            idx = int'(start) + k;
            if (idx >= int'(N)) begin
                idx = idx - int'(N);
            end
            if (req[idx]) begin
                winner = IW'(idx);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter feeding one shared FIFO write port; FIFO_ARB_STATS_EN adds per-requester beat counters.
// Latency: ownership is granted one cycle after a request in IDLE; beats pass to the FIFO combinationally.
// Backpressure: fifo_full gates req_ready and freezes burst count and ownership.
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter  int unsigned FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter  int unsigned MAX_BURST  = DEF_MAX_BURST,
    localparam int unsigned IW         = $clog2(NUM_REQ),
    localparam int unsigned BW         = $clog2(MAX_BURST + 1)
) (
    input  logic                                clk,
    input  logic                                rstN,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0][FIFO_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic                                fifo_full,
    output logic                                fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]               fifo_data,
    output logic [IW-1:0]                       grant_id,
`ifdef FIFO_ARB_STATS_EN
    input  logic [IW-1:0]                       stat_sel,
    output logic [15:0]                         stat_cnt,
`endif
    output logic                                busy
);

    arb_state_e    state_q;
    logic [IW-1:0] grant_q;
    logic [IW-1:0] last_q;
    logic [BW-1:0] burst_q;

    logic          own;
    logic [IW-1:0] pick_base;
    logic [IW-1:0] pick_start;
    logic [IW-1:0] pick_id;
    logic          pick_found;
    logic          last_beat;
    logic          release_own;

    assign own = (state_q == OWN);

    always_comb begin
        req_ready = '0;
        if (own && !fifo_full) begin
            req_ready[grant_q] = 1'b1;
        end
    end

    assign fifo_wr_en = req_valid[grant_q] & req_ready[grant_q];
    assign fifo_data  = own ? req_data[grant_q] : '0;
    assign grant_id   = grant_q;
    assign busy       = own;

    // Search resumes after the current owner when rotating, after the previous owner from IDLE.
    assign pick_base  = own ? grant_q : last_q;
    assign pick_start = (pick_base == IW'(NUM_REQ - 1)) ? '0 : pick_base + 1'b1;

    rr_pick #(
        .N(NUM_REQ)
    ) u_rr_pick (
        .req    (req_valid),
        .start  (pick_start),
        .winner (pick_id),
        .found  (pick_found)
    );

    assign last_beat   = fifo_wr_en && (burst_q == BW'(MAX_BURST - 1));
    assign release_own = own && (!req_valid[grant_q] || last_beat);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IW'(NUM_REQ - 1);
            burst_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        state_q <= OWN;
                        grant_q <= pick_id;
                        burst_q <= '0;
                    end
                end
                OWN: begin
                    if (release_own) begin
                        last_q  <= grant_q;
                        burst_q <= '0;
                        if (pick_found) begin
                            grant_q <= pick_id;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (fifo_wr_en) begin
                        burst_q <= burst_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] stat_q;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            stat_q <= '0;
        end else if (fifo_wr_en && (stat_q[grant_q] != 16'hFFFF)) begin
            stat_q[grant_q] <= stat_q[grant_q] + 1'b1;
        end
    end

    assign stat_cnt = stat_q[stat_sel];
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: expected beat owners are queued as stimulus is driven and popped per accepted beat.
module tb_fifo_wr_arb;

    logic            clk = 1'b0;
    logic            rstN;
    logic [3:0]      req_valid;
    logic [3:0][7:0] req_data;
    logic [3:0]      req_ready;
    logic            fifo_full;
    logic            fifo_wr_en;
    logic [7:0]      fifo_data;
    logic [1:0]      grant_id;
    logic            busy;

    logic [3:0]      v_b;
    logic [3:0][7:0] d_b;
    logic [3:0]      rdy_b;
    logic            full_b;
    logic            wr_b;
    logic [7:0]      fd_b;
    logic [1:0]      g_b;
    logic            busy_b;

`ifdef FIFO_ARB_STATS_EN
    logic [1:0]  stat_sel;
    logic [15:0] stat_cnt;
    logic [1:0]  stat_sel_b;
    logic [15:0] stat_cnt_b;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    fifo_wr_arb #(.NUM_REQ(4), .FIFO_WIDTH(8), .MAX_BURST(4)) dut (
        .clk        (clk),
        .rstN       (rstN),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_data  (fifo_data),
        .grant_id   (grant_id),
`ifdef FIFO_ARB_STATS_EN
        .stat_sel   (stat_sel),
        .stat_cnt   (stat_cnt),
`endif
        .busy       (busy)
    );

    fifo_wr_arb #(.NUM_REQ(4), .FIFO_WIDTH(8), .MAX_BURST(1)) dut_b (
        .clk        (clk),
        .rstN       (rstN),
        .req_valid  (v_b),
        .req_data   (d_b),
        .req_ready  (rdy_b),
        .fifo_full  (full_b),
        .fifo_wr_en (wr_b),
        .fifo_data  (fd_b),
        .grant_id   (g_b),
`ifdef FIFO_ARB_STATS_EN
        .stat_sel   (stat_sel_b),
        .stat_cnt   (stat_cnt_b),
`endif
        .busy       (busy_b)
    );

    function automatic logic [7:0] pat(input int id, input int c);
        return 8'((id * 16) + (c % 16));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive_data();
        for (int i = 0; i < 4; i++) begin
            req_data[i] = pat(i, cyc);
            d_b[i]      = pat(i, cyc);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        cyc++;
        drive_data();
    endtask

    task automatic push(input int id, input int n);
        repeat (n) exp_q.push_back(id);
    endtask

    task automatic beat(input string tag);
        int id;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s_sb observed=empty_queue expected=pending_beat", tag);
        end else begin
            id = exp_q.pop_front();
            chk({tag, "_wr"},    32'(fifo_wr_en), 32'd1);
            chk({tag, "_grant"}, 32'(grant_id),   32'(id));
            chk({tag, "_data"},  32'(fifo_data),  32'(pat(id, cyc)));
            chk({tag, "_ready"}, 32'(req_ready),  32'(1 << id));
        end
        next();
    endtask

    task automatic nobeat(input string tag, input logic exp_busy);
        @(negedge clk);
        chk({tag, "_wr"},   32'(fifo_wr_en), 32'd0);
        chk({tag, "_busy"}, 32'(busy),       32'(exp_busy));
        next();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstN      = 1'b0;
        req_valid = '0;
        fifo_full = 1'b0;
        v_b       = '0;
        full_b    = 1'b0;
`ifdef FIFO_ARB_STATS_EN
        stat_sel   = 2'd1;
        stat_sel_b = 2'd0;
`endif
        drive_data();
        #12;
        chk("rst_busy",  32'(busy),       32'd0);
        chk("rst_ready", 32'(req_ready),  32'd0);
        chk("rst_wr",    32'(fifo_wr_en), 32'd0);
        chk("rst_data",  32'(fifo_data),  32'd0);
        chk("rst_grant", 32'(grant_id),   32'd0);
        chk("rst_b_wr",  32'(wr_b),       32'd0);
        next();
        rstN = 1'b1;

        // Two requesters alternate full bursts with no idle gap.
        req_valid = 4'b0101;
        push(0, 4); push(2, 4); push(0, 4);
        nobeat("alt_idle0", 1'b0);
        repeat (12) beat("alt");
        req_valid = 4'b0000;
        nobeat("alt_drop", 1'b1);
        nobeat("alt_idle1", 1'b0);

        // Requester 1 drops after two beats; ownership moves straight to 3.
        req_valid = 4'b0010;
        nobeat("drop_idle", 1'b0);
        req_valid = 4'b1010;
        push(1, 2);
        repeat (2) beat("drop_r1");
        req_valid = 4'b1000;
        @(negedge clk);
        chk("drop_hold_wr",    32'(fifo_wr_en), 32'd0);
        chk("drop_hold_grant", 32'(grant_id),   32'd1);
        next();
        push(3, 1);
        beat("drop_r3");
        req_valid = 4'b0000;
        nobeat("drop_tail", 1'b1);
        nobeat("drop_idle2", 1'b0);

        // FIFO full for three cycles mid-burst; burst count must survive.
        req_valid = 4'b0100;
        nobeat("full_idle", 1'b0);
        req_valid = 4'b0110;
        push(2, 2);
        repeat (2) beat("full_pre");
        fifo_full = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("full_ready", 32'(req_ready),  32'd0);
            chk("full_wr",    32'(fifo_wr_en), 32'd0);
            chk("full_grant", 32'(grant_id),   32'd2);
            chk("full_busy",  32'(busy),       32'd1);
            next();
        end
        fifo_full = 1'b0;
        push(2, 2); push(1, 1);
        repeat (3) beat("full_post");
        req_valid = 4'b0000;
        nobeat("full_tail", 1'b1);
        nobeat("full_idle2", 1'b0);

        // Reset in the middle of a burst.
        req_valid = 4'b1111;
        nobeat("mid_idle", 1'b0);
        push(2, 2);
        repeat (2) beat("mid_r2");
        rstN = 1'b0;
        #1;
        chk("mid_rst_busy",  32'(busy),       32'd0);
        chk("mid_rst_ready", 32'(req_ready),  32'd0);
        chk("mid_rst_wr",    32'(fifo_wr_en), 32'd0);
        chk("mid_rst_data",  32'(fifo_data),  32'd0);
        chk("mid_rst_grant", 32'(grant_id),   32'd0);
        exp_q.delete();
        next();
        rstN = 1'b1;
        nobeat("post_rst_idle", 1'b0);
        push(0, 1);
        beat("post_rst_first");
        req_valid = 4'b0000;
        nobeat("post_rst_tail", 1'b1);
        nobeat("post_rst_idle2", 1'b0);

        // Ten beats from requester 1, re-granted to itself across burst boundaries.
        req_valid = 4'b0010;
        nobeat("ten_idle", 1'b0);
        push(1, 10);
        repeat (10) beat("ten");
        req_valid = 4'b0000;
        nobeat("ten_tail", 1'b1);
        nobeat("ten_idle2", 1'b0);
`ifdef FIFO_ARB_STATS_EN
        stat_sel = 2'd1;
        #1;
        chk("stat_r1", 32'(stat_cnt), 32'd10);
        stat_sel = 2'd0;
        #1;
        chk("stat_r0", 32'(stat_cnt), 32'd1);
`endif

        // Single-beat bursts rotate through every requester.
        v_b = 4'b1111;
        @(negedge clk);
        chk("mb1_idle_wr", 32'(wr_b),   32'd0);
        chk("mb1_idle_bz", 32'(busy_b), 32'd0);
        next();
        push(0, 1); push(1, 1); push(2, 1); push(3, 1); push(0, 1);
        repeat (5) begin
            int id;
            @(negedge clk);
            id = exp_q.pop_front();
            chk("mb1_wr",    32'(wr_b),  32'd1);
            chk("mb1_grant", 32'(g_b),   32'(id));
            chk("mb1_data",  32'(fd_b),  32'(pat(id, cyc)));
            chk("mb1_ready", 32'(rdy_b), 32'(1 << id));
            next();
        end
        v_b = 4'b0000;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of write requesters (2..8).
REQ-002 Parameter FIFO_WIDTH, default 8, SHALL set the data width and SHALL match the shared FIFO's data width.
REQ-003 Parameter MAX_BURST, default 4, SHALL set the maximum consecutive beats for one requester before rotation (1..16).
REQ-004 clk  input  1  clock; all state updates on posedge clk.
REQ-005 rstN  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  NUM_REQ  per-requester write request.
REQ-007 req_data  input  NUM_REQ x FIFO_WIDTH  per-requester write data.
REQ-008 req_ready  output  NUM_REQ  one-hot or zero; beat accepted when req_valid[i] && req_ready[i].
REQ-009 fifo_full  input  1  full flag from the shared FIFO.
REQ-010 fifo_wr_en  output  1  write strobe to the FIFO.
REQ-011 fifo_data  output  FIFO_WIDTH  write data to the FIFO.
REQ-012 grant_id  output  clog2(NUM_REQ)  index of the current owner; valid when busy=1.
REQ-013 busy  output  1  high while state is OWN.

Function
REQ-014 The FSM SHALL have two states: IDLE (no owner) and OWN (grant_id holds ownership).
REQ-015 In IDLE with any req_valid high, the next state SHALL be OWN, with grant_id = first requester with valid high, searching round-robin from (last_owner+1) mod NUM_REQ.
REQ-016 req_ready[grant_id] SHALL be 1 only in OWN with fifo_full=0; all other req_ready bits SHALL be 0.
REQ-017 fifo_wr_en SHALL equal req_valid[grant_id] && req_ready[grant_id], combinationally, with zero cycles of latency.
REQ-018 fifo_data SHALL equal req_data[grant_id] in OWN and 0 in IDLE.
REQ-019 A burst counter SHALL increment on each accepted beat and SHALL clear on ownership change.
REQ-020 OWN SHALL be released at the clock edge where either (a) the accepted beat brings the burst counter to MAX_BURST, or (b) req_valid[grant_id]=0.
REQ-021 On release, last_owner SHALL take the value of grant_id; if another request is pending, OWN SHALL continue with the next round-robin winner and no IDLE cycle; otherwise the next state SHALL be IDLE.
REQ-022 While fifo_full=1: no beat is accepted, the burst counter and ownership SHALL hold, and no rotation occurs.
REQ-023 A requester dropping valid while fifo_full=1 SHALL release ownership, per REQ-020(b).
REQ-024 With MAX_BURST=1, ownership SHALL rotate after every accepted beat.
REQ-025 In a single cycle, at most one beat SHALL be forwarded to the FIFO.

Reset
REQ-026 rstN low SHALL immediately set the state to IDLE, grant_id=0, last_owner=NUM_REQ-1, burst counter=0, busy=0, req_ready=0, fifo_wr_en=0, and fifo_data=0.
REQ-027 A reset in mid-burst SHALL drop the beat in flight; the first grant after reset SHALL search from requester 0.

Configuration
REQ-028 When FIFO_ARB_STATS_EN is defined, the block SHALL add the input stat_sel (clog2(NUM_REQ)) and the output stat_cnt (16 bits).
REQ-029 Under FIFO_ARB_STATS_EN, stat_cnt SHALL report the accepted-beat count for the selected requester; counters SHALL saturate at 16'hFFFF and SHALL clear on reset.
REQ-030 When FIFO_ARB_STATS_EN is undefined, these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-031 Package fifo_arb_pkg SHALL hold the state enum (IDLE, OWN) and the default-parameter constants.
REQ-032 Sub-module rr_pick SHALL be a combinational round-robin priority encoder with inputs (req vector, start index) and outputs (winner index, found).

Verification
REQ-033 With req_valid=4'b0101 held, fifo_full=0, and MAX_BURST=4 after reset, the bench SHALL check 4 beats from requester 0, then 4 from requester 2, alternating, with no idle cycle.
REQ-034 With requester 1 sending 2 beats then dropping valid while requester 3 is valid, the bench SHALL check that grant_id moves to 3 on the following cycle.
REQ-035 With fifo_full raised for 3 cycles during a burst of requester 2, the bench SHALL check req_ready=0 and fifo_wr_en=0 for those cycles, and that the burst resumes with the count preserved.
REQ-036 With rstN asserted mid-burst, the bench SHALL check that all outputs are 0 in the same cycle, and that after release with all requesters valid the first grant goes to requester 0.
REQ-037 With MAX_BURST=1 and all 4 requesters valid, the bench SHALL check the grant order 0,1,2,3,0 with one beat each.
REQ-038 With FIFO_ARB_STATS_EN defined and 10 beats from requester 1, the bench SHALL check that stat_sel=1 reads stat_cnt=10.
